// File: rtl/uart_rx_oversampler.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_oversampler
// Description : 16x-oversampled UART receiver. The raw serial pin is
//               synchronized, then sampled 16 times per bit. Each bit value
//               is the 2-of-3 majority of the samples taken at sub-ticks
//               7, 8 and 9, which rejects glitches and false starts. It
//               produces one parallel byte per frame with a single-cycle
//               valid strobe.
//               Optional feature macro: UART_RX_PARITY_EN. When it is
//               defined, an even-parity bit is expected after the data bits
//               and a Parity_Error output is added.
// Ports       : Clock_100MHz  - system clock, rising edge
//               Reset         - synchronous, active-high reset
//               TXD           - asynchronous serial line, idle high
//               UART_Data     - last good byte, LSB = first bit received
//               Data_Valid    - 1-cycle pulse, UART_Data updated on same edge
//               Framing_Error - 1-cycle pulse, stop bit sampled low
//               Busy          - high whenever the receiver is not idle
//               Parity_Error  - 1-cycle pulse on even-parity mismatch
//                               (only with UART_RX_PARITY_EN)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_oversampler #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BAUD_RATE   = 9_600,
    parameter int unsigned DATA_BITS   = 8
) (
    input  logic                 Clock_100MHz,
    input  logic                 Reset,
    input  logic                 TXD,
    output logic [DATA_BITS-1:0] UART_Data,
    output logic                 Data_Valid,
    output logic                 Framing_Error,
    output logic                 Busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 Parity_Error
`endif
);

    localparam int unsigned OVS_DIV = CLK_FREQ_HZ / (BAUD_RATE * 16);
    localparam int unsigned c_DIV_W = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(OVS_DIV - 1);
    localparam logic [2:0] c_BIT_LAST = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t                 state_q;
    logic                   sync1_q;
    logic                   rxs_q;
    logic [c_DIV_W-1:0]     div_q;
    logic [3:0]             sub_q;
    logic [2:0]             bit_q;
    logic                   v7_q;
    logic                   v8_q;
    logic                   vote_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [3:0]             brk_cnt_q;
`ifdef UART_RX_PARITY_EN
    logic                   parity_q;
`endif

    logic w_tick;
    logic w_maj;

    assign w_tick = (div_q == c_DIV_LAST);
    // Majority vote is resolved on the sub-tick 9 sample, using the two
    // earlier samples held in v7_q/v8_q and the live synchronized line.
    assign w_maj  = (v7_q & v8_q) | (v7_q & rxs_q) | (v8_q & rxs_q);
    assign Busy   = (state_q != S_IDLE);

    // Two-flop synchronizer; idles high like the line itself.
    always_ff @(posedge Clock_100MHz) begin
        if (Reset) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= TXD;
            rxs_q   <= sync1_q;
        end
    end

    always_ff @(posedge Clock_100MHz) begin
        if (Reset) begin
            state_q       <= S_IDLE;
            div_q         <= '0;
            sub_q         <= 4'd0;
            bit_q         <= 3'd0;
            v7_q          <= 1'b0;
            v8_q          <= 1'b0;
            vote_q        <= 1'b0;
            shift_q       <= '0;
            brk_cnt_q     <= 4'd0;
            UART_Data     <= '0;
            Data_Valid    <= 1'b0;
            Framing_Error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_q      <= 1'b0;
            Parity_Error  <= 1'b0;
`endif
        end else begin
            Data_Valid    <= 1'b0;
            Framing_Error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            Parity_Error  <= 1'b0;
`endif

            // Oversample divider; restarting it on the start edge puts the
            // sub-tick samples at a fixed offset from the falling edge.
            if (state_q == S_IDLE && !rxs_q) begin
                div_q <= '0;
            end else if (w_tick) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + 1'b1;
            end

            if (w_tick && state_q != S_IDLE) begin
                sub_q <= sub_q + 4'd1;
                if (sub_q == 4'd7) v7_q   <= rxs_q;
                if (sub_q == 4'd8) v8_q   <= rxs_q;
                if (sub_q == 4'd9) vote_q <= w_maj;
            end

            case (state_q)
                S_IDLE: begin
                    if (!rxs_q) begin
                        state_q <= S_START;
                        sub_q   <= 4'd0;
                    end
                end

                S_START: begin
                    if (w_tick) begin
                        if (sub_q == 4'd9 && w_maj) begin
                            state_q <= S_IDLE;      // false start
                        end else if (sub_q == 4'd15) begin
                            state_q <= S_DATA;
                            bit_q   <= 3'd0;
                        end
                    end
                end

                S_DATA: begin
                    if (w_tick && sub_q == 4'd15) begin
                        shift_q <= {vote_q, shift_q[DATA_BITS-1:1]};
                        if (bit_q == c_BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_tick && sub_q == 4'd15) begin
                        parity_q <= vote_q;
                        state_q  <= S_STOP;
                    end
                end
`endif

                // Decided mid stop bit so a following start edge is caught
                // even with zero idle time between frames.
                S_STOP: begin
                    if (w_tick && sub_q == 4'd9) begin
                        if (w_maj) begin
                            state_q <= S_IDLE;
`ifdef UART_RX_PARITY_EN
                            if (^{shift_q, parity_q}) begin
                                Parity_Error <= 1'b1;
                            end else begin
                                UART_Data  <= shift_q;
                                Data_Valid <= 1'b1;
                            end
`else
                            UART_Data  <= shift_q;
                            Data_Valid <= 1'b1;
`endif
                        end else begin
                            Framing_Error <= 1'b1;
                            state_q       <= S_BREAK;
                            brk_cnt_q     <= 4'd0;
                        end
                    end
                end

                // Held-low line: wait for 16 consecutive high ticks so a
                // break produces only the single error pulse above.
                S_BREAK: begin
                    if (w_tick) begin
                        if (rxs_q) begin
                            if (brk_cnt_q == 4'd15) begin
                                state_q <= S_IDLE;
                            end else begin
                                brk_cnt_q <= brk_cnt_q + 4'd1;
                            end
                        end else begin
                            brk_cnt_q <= 4'd0;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_oversampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_oversampler
// Description : Directed self-checking bench for uart_rx_oversampler at
//               CLK_FREQ_HZ=1_600_000, BAUD_RATE=10_000 (160 clocks per bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_oversampler;

    localparam int BIT_CLKS = 160;

    logic       clk = 1'b0;
    logic       rst;
    logic       txd;
    logic [7:0] uart_data;
    logic       data_valid;
    logic       framing_error;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
`endif

    always #5 clk = ~clk;

    uart_rx_oversampler #(
        .CLK_FREQ_HZ(1_600_000),
        .BAUD_RATE  (10_000),
        .DATA_BITS  (8)
    ) u_dut (
        .Clock_100MHz (clk),
        .Reset        (rst),
        .TXD          (txd),
        .UART_Data    (uart_data),
        .Data_Valid   (data_valid),
        .Framing_Error(framing_error),
        .Busy         (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .Parity_Error (parity_error)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Strobe monitor, sampled on the falling edge.
    int         dv_cnt   = 0;
    int         fe_cnt   = 0;
    int         pe_cnt   = 0;
    int         both_cnt = 0;
    int         wide_cnt = 0;
    logic [7:0] dq[$];
    logic       dv_prev  = 1'b0;
    logic       fe_prev  = 1'b0;

    always @(negedge clk) begin
        if (data_valid) begin
            dv_cnt++;
            dq.push_back(uart_data);
        end
        if (framing_error) fe_cnt++;
        if (data_valid && framing_error) both_cnt++;
        if ((data_valid && dv_prev) || (framing_error && fe_prev)) wide_cnt++;
        dv_prev = data_valid;
        fe_prev = framing_error;
`ifdef UART_RX_PARITY_EN
        if (parity_error) pe_cnt++;
`endif
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One bit period; optional single-clock inverted glitch at offset goff.
    task automatic drive_bit(input logic v, input bit glitch, input int goff);
        txd = v;
        if (glitch) begin
            wait_clks(goff);
            txd = ~v;
            wait_clks(1);
            txd = v;
            wait_clks(BIT_CLKS - goff - 1);
        end else begin
            wait_clks(BIT_CLKS);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input bit glitch,
                              input bit has_par, input logic par_v);
        drive_bit(1'b0, 1'b0, 0);
        for (int i = 0; i < 8; i++) drive_bit(d[i], glitch, 86 + i);
        if (has_par) drive_bit(par_v, 1'b0, 0);
        drive_bit(stop_v, 1'b0, 0);
    endtask

    function automatic logic [31:0] dq_at(input int idx);
        if (idx < dq.size()) return {24'h0, dq[idx]};
        return 32'hDEAD;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0, f0, p0, base;

        // Reset state
        rst = 1'b1;
        txd = 1'b1;
        wait_clks(5);
        check_val("rst_data",  {24'h0, uart_data}, 32'h0);
        check_val("rst_dv",    {31'h0, data_valid}, 32'h0);
        check_val("rst_fe",    {31'h0, framing_error}, 32'h0);
        check_val("rst_busy",  {31'h0, busy}, 32'h0);
        rst = 1'b0;
        wait_clks(BIT_CLKS);

        // Single clean 0xA5 frame
        d0 = dv_cnt; f0 = fe_cnt;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_clks(BIT_CLKS);
        check_val("a5_dv_cnt", dv_cnt - d0, 1);
        check_val("a5_data",   {24'h0, uart_data}, 32'hA5);
        check_val("a5_fe_cnt", fe_cnt - f0, 0);
        check_val("a5_busy",   {31'h0, busy}, 32'h0);

        // Back-to-back 0x00 then 0xFF, zero idle
        d0 = dv_cnt; base = dq.size();
        send_frame(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_clks(BIT_CLKS);
        check_val("b2b_dv_cnt", dv_cnt - d0, 2);
        check_val("b2b_first",  dq_at(base), 32'h00);
        check_val("b2b_second", dq_at(base + 1), 32'hFF);

        // 40-clock low glitch on an idle line
        d0 = dv_cnt; f0 = fe_cnt;
        txd = 1'b0;
        wait_clks(10);
        check_val("glitch_busy_hi", {31'h0, busy}, 32'h1);
        wait_clks(30);
        txd = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check_val("glitch_dv_cnt", dv_cnt - d0, 0);
        check_val("glitch_fe_cnt", fe_cnt - f0, 0);
        check_val("glitch_busy_lo", {31'h0, busy}, 32'h0);

        // 0x3C with low stop bit followed by a held-low line
        d0 = dv_cnt; f0 = fe_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_clks(5 * BIT_CLKS);
        check_val("brk_fe_cnt", fe_cnt - f0, 1);
        check_val("brk_dv_cnt", dv_cnt - d0, 0);
        check_val("brk_data",   {24'h0, uart_data}, 32'hFF);
        check_val("brk_busy_low_line", {31'h0, busy}, 32'h1);
        txd = 1'b1;
        wait_clks(100);
        check_val("brk_busy_early", {31'h0, busy}, 32'h1);
        wait_clks(100);
        check_val("brk_busy_done",  {31'h0, busy}, 32'h0);

        // 0x5A with a one-clock glitch in every data bit
        d0 = dv_cnt;
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_clks(BIT_CLKS);
        check_val("vote_dv_cnt", dv_cnt - d0, 1);
        check_val("vote_data",   {24'h0, uart_data}, 32'h5A);

        // Reset in the middle of the data bits
        d0 = dv_cnt; f0 = fe_cnt;
        drive_bit(1'b0, 1'b0, 0);
        drive_bit(1'b1, 1'b0, 0);
        drive_bit(1'b0, 1'b0, 0);
        drive_bit(1'b1, 1'b0, 0);
        rst = 1'b1;
        txd = 1'b1;
        wait_clks(3);
        check_val("mid_rst_data", {24'h0, uart_data}, 32'h0);
        check_val("mid_rst_busy", {31'h0, busy}, 32'h0);
        rst = 1'b0;
        wait_clks(3 * BIT_CLKS);
        check_val("mid_rst_dv_cnt", dv_cnt - d0, 0);
        check_val("mid_rst_fe_cnt", fe_cnt - f0, 0);
        check_val("mid_rst_dv",     {31'h0, data_valid}, 32'h0);
        send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_clks(BIT_CLKS);
        check_val("post_rst_dv_cnt", dv_cnt - d0, 1);
        check_val("post_rst_data",   {24'h0, uart_data}, 32'h81);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones: even parity bit must be 1
        d0 = dv_cnt; p0 = pe_cnt;
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_clks(BIT_CLKS);
        check_val("par_bad_pe_cnt", pe_cnt - p0, 1);
        check_val("par_bad_dv_cnt", dv_cnt - d0, 0);
        check_val("par_bad_data",   {24'h0, uart_data}, 32'h81);
        d0 = dv_cnt; p0 = pe_cnt;
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_clks(BIT_CLKS);
        check_val("par_ok_dv_cnt", dv_cnt - d0, 1);
        check_val("par_ok_pe_cnt", pe_cnt - p0, 0);
        check_val("par_ok_data",   {24'h0, uart_data}, 32'h07);
`else
        p0 = pe_cnt;
        check_val("no_par_pe_cnt", pe_cnt - p0, 0);
`endif

        // Whole-run strobe properties
        check_val("dv_fe_exclusive", both_cnt, 0);
        check_val("strobe_width",    wide_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
